// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the pipeline hazard scoreboard.
// Control bundle, forwarding/branch/writeback enums, FSM and policy enums.
package hazard_scoreboard_pkg;

    typedef enum logic [1:0] {
        DECODE,
        EXECUTE,
        MEMORY,
        WRITEBACK
    } forward_t;

    typedef enum logic [2:0] {
        NEVER,
        ALWAYS,
        EQ,
        NE,
        LT,
        GE,
        LTU,
        GEU
    } branch_mode_t;

    typedef enum logic [1:0] {
        ALU,
        MEM,
        PC4,
        IMM
    } wb_select_t;

    typedef enum logic {
        IDLE,
        BUSY
    } md_state_t;

    typedef enum logic {
        STALL,
        PREDICT_NOT_TAKEN
    } branch_policy_t;

    typedef struct packed {
        logic         write_reg;
        logic [4:0]   rd;
        wb_select_t   wb_select;
        branch_mode_t branch_mode;
        logic         is_muldiv;
    } control_t;

    function automatic logic writes_reg(control_t c, logic [4:0] rs);
        return c.write_reg && (c.rd == rs) && (rs != 5'd0);
    endfunction

    function automatic logic is_load(control_t c);
        return (c.wb_select == MEM) && c.write_reg && (c.rd != 5'd0);
    endfunction

    function automatic logic is_branch(control_t c);
        return c.branch_mode != NEVER;
    endfunction

endpackage

// File: rtl/md_stall_timer.sv
// Mul/div occupancy timer: stalls the front of the pipe while a
// multi-cycle op sits in EX. Ports: clk, reset, start (muldiv in EX), stall.
module md_stall_timer
    import hazard_scoreboard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    output logic stall
);

    localparam int            CW    = $clog2(MD_LATENCY) + 1;
    localparam logic [CW-1:0] LOAD  = CW'(MD_LATENCY - 1);
    localparam logic [CW-1:0] LAST  = CW'(1);
    localparam bit            MULTI = (MD_LATENCY > 1);

    md_state_t     state_q, state_d;
    logic [CW-1:0] md_cnt_q, md_cnt_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // The op is still in EX on the release cycle, so BUSY ignores start.
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        stall    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && MULTI && !reset) begin
                    stall    = 1'b1;
                    md_cnt_d = LOAD;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                md_cnt_d = md_cnt_q - LAST;
                if (md_cnt_q == LAST) begin
                    state_d = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard controller: forwarding, load-use stall, branch stall/flush,
// mul/div freeze, saturating stall/flush counters.
// In: clk, reset, id/ex/mem/wb_control, rs1, rs2, should_branch.
// Out: hazard, pipe enables, flushes, forward selects, md_busy, counters.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int             MD_LATENCY    = 4,
    parameter branch_policy_t BRANCH_POLICY = STALL,
    parameter bit             LOAD_FWD_MEM  = 1'b0,
    parameter int             CNT_WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  control_t             id_control,
    input  logic [4:0]           rs1,
    input  logic [4:0]           rs2,
    input  control_t             ex_control,
    input  control_t             mem_control,
    input  control_t             wb_control,
    input  logic                 should_branch,
    output logic                 hazard,
    output logic                 if_pc_write_enable,
    output logic                 ifid_write_enable,
    output logic                 idex_write_enable,
    output logic                 ifid_flush,
    output logic                 idex_flush,
    output forward_t             forward_rs1,
    output forward_t             forward_rs2,
    output logic                 md_busy,
    output logic [CNT_WIDTH-1:0] stall_count,
    output logic [CNT_WIDTH-1:0] flush_count
);

    localparam bit PNT = (BRANCH_POLICY == PREDICT_NOT_TAKEN);

    logic     md_stall;
    logic     br_id, br_ex, br_mem, taken;
    logic     lu_ex, lu_mem, load_use;
    forward_t fwd1, fwd2;

    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic unused_bits;
    assign unused_bits = ^{id_control, mem_control, wb_control};

    md_stall_timer #(
        .MD_LATENCY(MD_LATENCY)
    ) u_md (
        .clk  (clk),
        .reset(reset),
        .start(ex_control.is_muldiv),
        .stall(md_stall)
    );

    function automatic forward_t fwd_sel(logic [4:0] rs);
        if (writes_reg(ex_control, rs))       return EXECUTE;
        else if (writes_reg(mem_control, rs)) return MEMORY;
        else if (writes_reg(wb_control, rs))  return WRITEBACK;
        else                                  return DECODE;
    endfunction

    function automatic logic load_hit(control_t c);
        return is_load(c) && ((c.rd == rs1) || (c.rd == rs2));
    endfunction

    assign fwd1     = fwd_sel(rs1);
    assign fwd2     = fwd_sel(rs2);
    assign br_id    = is_branch(id_control);
    assign br_ex    = is_branch(ex_control);
    assign br_mem   = is_branch(mem_control);
    assign taken    = br_ex && should_branch;
    assign lu_ex    = load_hit(ex_control);
    assign lu_mem   = load_hit(mem_control) && !LOAD_FWD_MEM;
    assign load_use = lu_ex || lu_mem;

    // A branch in MEM only flags the hazard; it never blocks a load-use
    // stall or an ID-branch freeze behind it.
    always_comb begin
        if_pc_write_enable = 1'b1;
        ifid_write_enable  = 1'b1;
        idex_write_enable  = 1'b1;
        ifid_flush         = 1'b0;
        idex_flush         = 1'b0;
        forward_rs1        = fwd1;
        forward_rs2        = fwd2;
        hazard             = 1'b0;
        if (reset) begin
            forward_rs1 = DECODE;
            forward_rs2 = DECODE;
        end else if (md_stall) begin
            if_pc_write_enable = 1'b0;
            ifid_write_enable  = 1'b0;
            idex_write_enable  = 1'b0;
            hazard             = 1'b1;
        end else if (PNT && taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            hazard     = 1'b1;
        end else if (!PNT && br_ex) begin
            if_pc_write_enable = should_branch;
            ifid_write_enable  = 1'b0;
            hazard             = 1'b1;
        end else if (load_use) begin
            if_pc_write_enable = 1'b0;
            ifid_write_enable  = 1'b0;
            idex_flush         = 1'b1;
            forward_rs1        = DECODE;
            forward_rs2        = DECODE;
            hazard             = 1'b1;
        end else if (!PNT && br_id) begin
            if_pc_write_enable = 1'b0;
            ifid_write_enable  = 1'b0;
            hazard             = 1'b1;
        end
        if (!reset && !PNT && br_mem) begin
            hazard = 1'b1;
        end
    end

    assign md_busy = md_stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!if_pc_write_enable && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end
        if ((ifid_flush || idex_flush) && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule
